// File: rtl/wb_fifo_pkg.sv
// Shared definitions for the Wishbone FIFO slave: register offsets, bit indices,
// response FSM states and a byte-lane merge helper.
package wb_fifo_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_THRESH = 2'd3;

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned CTRL_CLEAR_BIT   = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    FLUSH = 2'd2
  } resp_state_t;

  // Replace only the byte lanes enabled by sel.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        res[b*8 +: 8] = new_val[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_val[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x 32 synchronous FIFO storage with push/pop/clear and occupancy flags.
// The head entry is presented combinationally so a pop can capture it on accept.
module sync_fifo_mem #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push & ~o_full & ~i_clear;
  assign w_do_pop  = i_pop & ~o_empty & ~i_clear;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == (AW+1)'(0));

endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone pipelined slave exposing a 32-bit FIFO as DATA/STATUS/CTRL/THRESH registers.
// Define WB_FIFO_IRQ_EN to enable the threshold interrupt and the THRESH register.
module wb_fifo_slave
  import wb_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] ADDR_BASE = 32'h4000_0000
) (
  input  logic        wb_clk,
  input  logic        reset,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_stall,
  output logic        irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  resp_state_t r_state;
  resp_state_t w_state_nxt;

  logic [CW-1:0] w_count;
  logic [7:0]    w_count8;
  logic          w_full;
  logic          w_empty;
  logic [31:0]   w_head;

  logic [1:0]    w_off;
  logic          w_accept;
  logic          w_bad_adr;
  logic          w_bad_op;
  logic          w_error;
  logic          w_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_clear;
  logic          w_ctrl_wr;
  logic [31:0]   w_rdata;
  logic          w_irq_en;
  logic [31:0]   w_thresh;

  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_dat_o;

  sync_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (wb_clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_wdata (wb_dat_i),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_count8 = 8'(w_count);
  assign wb_stall = (r_state == FLUSH);
  assign w_accept = wb_cyc & wb_stb & ~wb_stall;
  assign w_off    = wb_adr[3:2];

  // Address decode and error classification of the current request.
  always_comb begin
    w_bad_adr = (wb_adr[31:4] != ADDR_BASE[31:4]) || (wb_adr[1:0] != 2'b00);
    w_bad_op  = 1'b0;
    case (w_off)
      OFF_DATA: begin
        if (wb_sel != 4'hF) begin
          w_bad_op = 1'b1;
        end else if (wb_we) begin
          w_bad_op = w_full;
        end else begin
          w_bad_op = w_empty;
        end
      end
      OFF_STATUS: w_bad_op = wb_we;
      OFF_CTRL:   w_bad_op = 1'b0;
`ifdef WB_FIFO_IRQ_EN
      OFF_THRESH: w_bad_op = 1'b0;
`else
      OFF_THRESH: w_bad_op = wb_we;
`endif
      default:    w_bad_op = 1'b1;
    endcase
    w_error = w_bad_adr | w_bad_op;
  end

  assign w_ok      = w_accept & ~w_error;
  assign w_push    = w_ok & wb_we & (w_off == OFF_DATA);
  assign w_pop     = w_ok & ~wb_we & (w_off == OFF_DATA);
  assign w_ctrl_wr = w_ok & wb_we & (w_off == OFF_CTRL) & wb_sel[0];
  assign w_clear   = w_ctrl_wr & wb_dat_i[CTRL_CLEAR_BIT];

  // Read-data mux; CLEAR always reads back as zero.
  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      OFF_DATA:   w_rdata = w_head;
      OFF_STATUS: w_rdata = {16'h0, w_count8, 6'h0, w_full, w_empty};
      OFF_CTRL:   w_rdata = {30'h0, w_irq_en, 1'b0};
      OFF_THRESH: w_rdata = w_thresh;
      default:    w_rdata = 32'h0;
    endcase
  end

  // Response FSM next state; a CLEAR write stalls the bus for one cycle.
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept && w_clear) begin
          w_state_nxt = FLUSH;
        end else if (w_accept) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FLUSH:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered bus response; reset drops any pending response.
  always_ff @(posedge wb_clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ok;
      r_err   <= w_accept & w_error;
      r_dat_o <= (w_ok && !wb_we) ? w_rdata : 32'h0;
    end
  end

`ifdef WB_FIFO_IRQ_EN
  logic        r_irq_en;
  logic [31:0] r_thresh;
  logic        r_irq;

  // Control/threshold registers and the level interrupt, one cycle behind count.
  always_ff @(posedge wb_clk) begin
    if (!reset) begin
      r_irq_en <= 1'b0;
      r_thresh <= 32'h0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_irq_en <= wb_dat_i[CTRL_IRQ_EN_BIT];
      end
      if (w_ok && wb_we && (w_off == OFF_THRESH)) begin
        r_thresh <= apply_sel(r_thresh, wb_dat_i, wb_sel);
      end
      r_irq <= r_irq_en & (9'(w_count) >= {1'b0, r_thresh[7:0]}) & ~w_empty;
    end
  end

  assign w_irq_en = r_irq_en;
  assign w_thresh = r_thresh;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign w_thresh = 32'h0;
  assign irq      = 1'b0;
`endif

  assign wb_ack   = r_ack;
  assign wb_err   = r_err;
  assign wb_dat_o = r_dat_o;

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Self-checking bench for wb_fifo_slave: per-feature tasks with a FIFO scoreboard.
module tb_wb_fifo_slave;

  localparam logic [31:0] A_DATA = 32'h4000_0000;
  localparam logic [31:0] A_STAT = 32'h4000_0004;
  localparam logic [31:0] A_CTRL = 32'h4000_0008;
  localparam logic [31:0] A_THR  = 32'h4000_000C;

  logic        wb_clk = 1'b0;
  logic        reset;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
  logic        wb_ack, wb_err, wb_stall, irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_q[$];  // contents the FIFO should hold
  logic [31:0] exp_q[$];    // expected read data, pushed when a pop is issued

  wb_fifo_slave dut (
    .wb_clk(wb_clk), .reset(reset), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall), .irq(irq)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, required finish before 400us");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_sel = 4'h0; wb_adr = 32'h0; wb_dat_i = 32'h0;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_sel = sel; wb_adr = adr; wb_dat_i = dat;
  endtask

  // One access; response sampled at the negedge right after the accepting posedge.
  task automatic single(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, output logic ack, output logic err,
                        output logic [31:0] rd, output logic stall);
    int n;
    n = 0;
    @(negedge wb_clk);
    while (wb_stall && n < 16) begin
      @(negedge wb_clk);
      n++;
    end
    if (n >= 16) begin
      checks++; failures++;
      $display("FAIL stall_timeout adr=%h stall=1 required 0", adr);
    end
    drive_req(we, adr, sel, dat);
    @(posedge wb_clk);
    @(negedge wb_clk);
    ack = wb_ack; err = wb_err; rd = wb_dat_o; stall = wb_stall;
    drive_idle();
  endtask

  task automatic test_reset();
    logic a, e, s; logic [31:0] d;
    reset = 1'b0;
    drive_idle();
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    checks++;
    if ({wb_ack, wb_err, wb_stall, irq, wb_dat_o} !== 36'h0) begin
      failures++;
      $display("FAIL reset_outputs got ack=%b err=%b stall=%b irq=%b dat=%h required all 0",
               wb_ack, wb_err, wb_stall, irq, wb_dat_o);
    end
    reset = 1'b1;
    single(1'b0, A_STAT, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (a !== 1'b1 || d !== 32'h0000_0001) begin
      failures++; $display("FAIL reset_status got ack=%b dat=%h required ack=1 dat=00000001", a, d);
    end
    single(1'b0, A_CTRL, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (a !== 1'b1 || d !== 32'h0) begin
      failures++; $display("FAIL reset_ctrl got ack=%b dat=%h required ack=1 dat=0", a, d);
    end
    single(1'b0, A_THR, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (a !== 1'b1 || d !== 32'h0) begin
      failures++; $display("FAIL reset_thresh got ack=%b dat=%h required ack=1 dat=0", a, d);
    end
  endtask

  task automatic test_push_pop();
    logic a, e, s; logic [31:0] d, x;
    logic [31:0] vals [2];
    vals[0] = 32'hDEAD_BEEF; vals[1] = 32'h0000_0001;
    for (int i = 0; i < 2; i++) begin
      model_q.push_back(vals[i]);
      single(1'b1, A_DATA, 4'hF, vals[i], a, e, d, s);
      checks++;
      if ({a, e} !== 2'b10) begin
        failures++; $display("FAIL push_ack[%0d] got ack=%b err=%b required ack=1 err=0", i, a, e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model_q.pop_front());
      single(1'b0, A_DATA, 4'hF, 32'h0, a, e, d, s);
      x = exp_q.pop_front();
      checks++;
      if (a !== 1'b1 || e !== 1'b0 || d !== x) begin
        failures++; $display("FAIL pop_data[%0d] got ack=%b dat=%h required ack=1 dat=%h", i, a, d, x);
      end
    end
    single(1'b0, A_STAT, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (d !== 32'h0000_0001) begin
      failures++; $display("FAIL pop_status got %h required 00000001", d);
    end
  endtask

  task automatic test_full_empty();
    logic a, e, s; logic [31:0] d, x;
    for (int i = 0; i < 16; i++) begin
      x = 32'hA000_0000 + 32'(i * 17);
      model_q.push_back(x);
      single(1'b1, A_DATA, 4'hF, x, a, e, d, s);
    end
    single(1'b0, A_STAT, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (d !== 32'h0000_1002) begin
      failures++; $display("FAIL full_status got %h required 00001002", d);
    end
    single(1'b1, A_DATA, 4'hF, 32'h1234_5678, a, e, d, s);
    checks++;
    if ({a, e} !== 2'b01 || d !== 32'h0) begin
      failures++; $display("FAIL push_full got ack=%b err=%b dat=%h required ack=0 err=1 dat=0", a, e, d);
    end
    single(1'b0, A_STAT, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (d !== 32'h0000_1002) begin
      failures++; $display("FAIL full_status_after_err got %h required 00001002", d);
    end
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(model_q.pop_front());
      single(1'b0, A_DATA, 4'hF, 32'h0, a, e, d, s);
      x = exp_q.pop_front();
      checks++;
      if (a !== 1'b1 || d !== x) begin
        failures++; $display("FAIL drain[%0d] got ack=%b dat=%h required ack=1 dat=%h", i, a, d, x);
      end
    end
    single(1'b0, A_DATA, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if ({a, e} !== 2'b01 || d !== 32'h0) begin
      failures++; $display("FAIL pop_empty got ack=%b err=%b dat=%h required ack=0 err=1 dat=0", a, e, d);
    end
  endtask

  task automatic test_wrap();
    logic a, e, s; logic [31:0] d, x;
    int pops;
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      model_q.push_back(x);
      single(1'b1, A_DATA, 4'hF, x, a, e, d, s);
      if (i >= 2) begin
        exp_q.push_back(model_q.pop_front());
        single(1'b0, A_DATA, 4'hF, 32'h0, a, e, d, s);
        x = exp_q.pop_front();
        pops++;
        checks++;
        if (a !== 1'b1 || d !== x) begin
          failures++; $display("FAIL wrap_pop[%0d] got ack=%b dat=%h required ack=1 dat=%h", pops, a, d, x);
        end
      end
    end
    while (model_q.size() > 0) begin
      exp_q.push_back(model_q.pop_front());
      single(1'b0, A_DATA, 4'hF, 32'h0, a, e, d, s);
      x = exp_q.pop_front();
      pops++;
      checks++;
      if (a !== 1'b1 || d !== x) begin
        failures++; $display("FAIL wrap_tail[%0d] got ack=%b dat=%h required ack=1 dat=%h", pops, a, d, x);
      end
    end
  endtask

  task automatic test_errors();
    logic a, e, s; logic [31:0] d, x;
    logic [31:0] adrs [4];
    logic [3:0]  sels [4];
    logic        wes  [4];
    adrs[0] = 32'h4000_0010; sels[0] = 4'hF; wes[0] = 1'b0;
    adrs[1] = 32'h4000_0002; sels[1] = 4'hF; wes[1] = 1'b0;
    adrs[2] = A_DATA;        sels[2] = 4'h3; wes[2] = 1'b1;
    adrs[3] = A_STAT;        sels[3] = 4'hF; wes[3] = 1'b1;
    model_q.push_back(32'h0000_00A5);
    single(1'b1, A_DATA, 4'hF, 32'h0000_00A5, a, e, d, s);
    for (int i = 0; i < 4; i++) begin
      single(wes[i], adrs[i], sels[i], 32'hFFFF_FFFF, a, e, d, s);
      checks++;
      if ({a, e} !== 2'b01 || d !== 32'h0) begin
        failures++; $display("FAIL err_case[%0d] got ack=%b err=%b dat=%h required ack=0 err=1 dat=0", i, a, e, d);
      end
    end
    single(1'b0, A_STAT, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (d !== 32'h0000_0100) begin
      failures++; $display("FAIL err_no_state_change got %h required 00000100", d);
    end
    exp_q.push_back(model_q.pop_front());
    single(1'b0, A_DATA, 4'hF, 32'h0, a, e, d, s);
    x = exp_q.pop_front();
    checks++;
    if (d !== x) begin
      failures++; $display("FAIL err_data_intact got %h required %h", d, x);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x;
    @(negedge wb_clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        checks++;
        if (wb_ack !== 1'b1 || wb_err !== 1'b0) begin
          failures++; $display("FAIL b2b_push[%0d] got ack=%b err=%b required ack=1 err=0", i - 1, wb_ack, wb_err);
        end
      end
      if (i < 4) begin
        x = 32'hB000_0000 + 32'(i);
        model_q.push_back(x);
        drive_req(1'b1, A_DATA, 4'hF, x);
      end else begin
        drive_idle();
      end
      @(negedge wb_clk);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_o !== x) begin
          failures++; $display("FAIL b2b_pop[%0d] got ack=%b dat=%h required ack=1 dat=%h", i - 1, wb_ack, wb_dat_o, x);
        end
      end
      if (i < 4) begin
        exp_q.push_back(model_q.pop_front());
        drive_req(1'b0, A_DATA, 4'hF, 32'h0);
      end else begin
        drive_idle();
      end
      @(negedge wb_clk);
    end
  endtask

  task automatic test_clear_and_reset();
    logic a, e, s; logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      single(1'b1, A_DATA, 4'hF, 32'(i + 100), a, e, d, s);
    end
    single(1'b1, A_CTRL, 4'hF, 32'h0000_0001, a, e, d, s);
    checks++;
    if (a !== 1'b1 || s !== 1'b1) begin
      failures++; $display("FAIL clear_stall got ack=%b stall=%b required ack=1 stall=1", a, s);
    end
    @(negedge wb_clk);
    checks++;
    if (wb_stall !== 1'b0 || wb_ack !== 1'b0) begin
      failures++; $display("FAIL clear_stall_len got stall=%b ack=%b required stall=0 ack=0", wb_stall, wb_ack);
    end
    single(1'b0, A_STAT, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (d !== 32'h0000_0001) begin
      failures++; $display("FAIL clear_status got %h required 00000001", d);
    end
    single(1'b0, A_CTRL, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL clear_ctrl_read got %h required 0", d);
    end
    single(1'b1, A_DATA, 4'hF, 32'h5555_AAAA, a, e, d, s);
    @(negedge wb_clk);
    drive_req(1'b0, A_DATA, 4'hF, 32'h0);
    reset = 1'b0;
    @(negedge wb_clk);
    checks++;
    if ({wb_ack, wb_err, wb_stall, irq, wb_dat_o} !== 36'h0) begin
      failures++;
      $display("FAIL reset_mid_pop got ack=%b err=%b stall=%b irq=%b dat=%h required all 0",
               wb_ack, wb_err, wb_stall, irq, wb_dat_o);
    end
    drive_idle();
    reset = 1'b1;
    single(1'b0, A_STAT, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (d !== 32'h0000_0001) begin
      failures++; $display("FAIL reset_mid_pop_status got %h required 00000001", d);
    end
  endtask

  task automatic test_irq();
    logic a, e, s; logic [31:0] d, x;
`ifdef WB_FIFO_IRQ_EN
    single(1'b1, A_THR, 4'hF, 32'h0000_0003, a, e, d, s);
    single(1'b1, A_CTRL, 4'hF, 32'h0000_0002, a, e, d, s);
    single(1'b0, A_CTRL, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++; $display("FAIL irq_ctrl_read got %h required 00000002", d);
    end
    for (int i = 0; i < 3; i++) begin
      x = 32'hC000_0000 + 32'(i);
      model_q.push_back(x);
      single(1'b1, A_DATA, 4'hF, x, a, e, d, s);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_early got %b required 0", irq);
    end
    @(negedge wb_clk);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL irq_set got %b required 1", irq);
    end
    exp_q.push_back(model_q.pop_front());
    single(1'b0, A_DATA, 4'hF, 32'h0, a, e, d, s);
    x = exp_q.pop_front();
    checks++;
    if (d !== x) begin
      failures++; $display("FAIL irq_pop got %h required %h", d, x);
    end
    @(negedge wb_clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_clear got %b required 0", irq);
    end
    single(1'b1, A_CTRL, 4'hF, 32'h0000_0001, a, e, d, s);
    model_q.delete();
`else
    single(1'b1, A_THR, 4'hF, 32'h0000_0003, a, e, d, s);
    checks++;
    if ({a, e} !== 2'b01) begin
      failures++; $display("FAIL thresh_write got ack=%b err=%b required ack=0 err=1", a, e);
    end
    single(1'b1, A_CTRL, 4'hF, 32'h0000_0002, a, e, d, s);
    for (int i = 0; i < 3; i++) begin
      single(1'b1, A_DATA, 4'hF, 32'(i), a, e, d, s);
    end
    @(negedge wb_clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_tied got %b required 0", irq);
    end
    single(1'b0, A_CTRL, 4'hF, 32'h0, a, e, d, s);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL ctrl_irqen_raz got %h required 0", d);
    end
    single(1'b1, A_CTRL, 4'hF, 32'h0000_0001, a, e, d, s);
    x = 32'h0;
`endif
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_push_pop();
    test_full_empty();
    test_wrap();
    test_errors();
    test_back_to_back();
    test_clear_and_reset();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
